// File: rtl/riscv_fetch.sv
// Single-issue instruction fetch stage: requests one word at a time from instruction memory,
// holds it for the consumer, and follows redirects from branch/jump resolution.
module riscv_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    input  logic                  stall,
    output logic [DATA_WIDTH-1:0] pc,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [24:0]           imm_data,
    output logic                  misalign
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10
    } state_t;

    localparam logic [DATA_WIDTH-1:0] PC_STEP = {{(DATA_WIDTH-3){1'b0}}, 3'd4};

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_instr;
    logic                  r_imem_req;
    logic                  r_instr_valid;
    logic                  r_misalign;

    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_pc_nxt;
    logic [DATA_WIDTH-1:0] w_instr_nxt;
    logic                  w_misalign_nxt;
    logic [DATA_WIDTH-1:0] w_target_aligned;
    logic                  w_target_misaligned;

    assign w_target_aligned    = {redirect_target[DATA_WIDTH-1:2], 2'b00};
    assign w_target_misaligned = (redirect_target[1:0] != 2'b00);

    // Next-state and datapath update; a redirect always takes priority over ack data and stall.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_misalign_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                if (redirect_valid) begin
                    w_pc_nxt       = w_target_aligned;
                    w_misalign_nxt = w_target_misaligned;
                end else if (imem_ack) begin
                    w_instr_nxt = imem_rdata;
                    w_state_nxt = HOLD;
                end else begin
                    w_state_nxt = FETCH;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    w_pc_nxt       = w_target_aligned;
                    w_instr_nxt    = NOP_INSTR;
                    w_misalign_nxt = w_target_misaligned;
                    w_state_nxt    = FETCH;
                end else if (!stall) begin
                    w_pc_nxt    = r_pc + PC_STEP;
                    w_state_nxt = FETCH;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; request/valid are registered decodes of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_misalign    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_imem_req    <= (w_state_nxt == FETCH);
            r_instr_valid <= (w_state_nxt == HOLD);
            r_misalign    <= w_misalign_nxt;
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign imm_data    = r_instr[31:7];
    assign misalign    = r_misalign;

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed self-checking bench for riscv_fetch: one task per scenario, inline comparisons.
module tb_riscv_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        stall;
    logic [31:0] pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [24:0] imm_data;
    logic        misalign;

    int checks;
    int errors;

    localparam logic [31:0] NOP = 32'h0000_0013;

    riscv_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall           (stall),
        .pc              (pc),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .imm_data        (imm_data),
        .misalign        (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; redirect_valid = 1'b0;
        redirect_target = 32'h0; stall = 1'b0;
        #2;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
        checks++; if (instr !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", instr, NOP); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", misalign); end
        tick();
        tick();
        rst = 1'b0;
        // ack presented while still idle must be ignored
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got %b exp 0", imem_req); end
        tick();
        imem_ack = 1'b0;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr got %h exp %h", imem_addr, 32'h0); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL idle_ack_valid got %b exp 0", instr_valid); end
        checks++; if (instr !== NOP) begin errors++; $display("FAIL idle_ack_instr got %h exp %h", instr, NOP); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_addr;
        logic [31:0] word;
        imem_ack = 1'b1; stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_addr = 32'(4 * i);
            word     = 32'h1000_0000 + 32'(i);
            imem_rdata = word;
            checks++; if (imem_req !== 1'b1 || imem_addr !== exp_addr || instr_valid !== 1'b0) begin
                errors++; $display("FAIL zw_fetch%0d got req=%b addr=%h v=%b exp req=1 addr=%h v=0", i, imem_req, imem_addr, instr_valid, exp_addr);
            end
            tick();
            checks++; if (instr_valid !== 1'b1 || instr !== word || pc !== exp_addr || imem_req !== 1'b0) begin
                errors++; $display("FAIL zw_hold%0d got v=%b instr=%h pc=%h req=%b exp v=1 instr=%h pc=%h req=0", i, instr_valid, instr, pc, imem_req, word, exp_addr);
            end
            tick();
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_delayed_ack();
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin imem_ack = 1'b1; imem_rdata = 32'h00A0_0093; end
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_000C || instr_valid !== 1'b0) begin
                errors++; $display("FAIL dly_req%0d got req=%b addr=%h v=%b exp req=1 addr=0000000c v=0", c, imem_req, imem_addr, instr_valid);
            end
            tick();
        end
        imem_ack = 1'b0; stall = 1'b1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL dly_req_drop got %b exp 0", imem_req); end
        checks++; if (instr !== 32'h00A0_0093) begin errors++; $display("FAIL dly_instr got %h exp 00a00093", instr); end
        checks++; if (imm_data !== 25'h0014001) begin errors++; $display("FAIL dly_imm got %h exp 0014001", imm_data); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL dly_valid got %b exp 1", instr_valid); end
    endtask

    task automatic test_stall();
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (instr !== 32'h00A0_0093 || pc !== 32'h0000_000C || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
                errors++; $display("FAIL stall%0d got instr=%h pc=%h v=%b req=%b exp instr=00a00093 pc=0000000c v=1 req=0", c, instr, pc, instr_valid, imem_req);
            end
        end
        stall = 1'b0;
        tick();
        checks++; if (pc !== 32'h0000_0010 || imem_addr !== 32'h0000_0010 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL stall_release got pc=%h addr=%h req=%b v=%b exp pc=00000010 addr=00000010 req=1 v=0", pc, imem_addr, imem_req, instr_valid);
        end
    endtask

    task automatic test_redirect_hold();
        imem_ack = 1'b1; imem_rdata = 32'h0040_0113;
        tick();
        imem_ack = 1'b0; stall = 1'b1;
        redirect_valid = 1'b1; redirect_target = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
        checks++; if (pc !== 32'h0000_0100 || imem_addr !== 32'h0000_0100) begin
            errors++; $display("FAIL rh_pc got pc=%h addr=%h exp 00000100", pc, imem_addr);
        end
        checks++; if (instr !== NOP || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
            errors++; $display("FAIL rh_flush got instr=%h v=%b req=%b exp instr=%h v=0 req=1", instr, instr_valid, imem_req, NOP);
        end
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL rh_misalign_on got %b exp 1", misalign); end
        tick();
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rh_misalign_off got %b exp 0", misalign); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
            errors++; $display("FAIL rh_wait got req=%b addr=%h exp req=1 addr=00000100", imem_req, imem_addr);
        end
        stall = 1'b0;
    endtask

    task automatic test_redirect_fetch();
        imem_ack = 1'b1; imem_rdata = 32'h0BAD_C0DE;
        redirect_valid = 1'b1; redirect_target = 32'h0000_0200;
        tick();
        imem_ack = 1'b0; redirect_valid = 1'b0;
        checks++; if (pc !== 32'h0000_0200 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL rf_state got pc=%h req=%b v=%b exp pc=00000200 req=1 v=0", pc, imem_req, instr_valid);
        end
        checks++; if (instr !== NOP || misalign !== 1'b0) begin
            errors++; $display("FAIL rf_discard got instr=%h mis=%b exp instr=%h mis=0", instr, misalign, NOP);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
        tick();
        imem_ack = 1'b0;
        checks++; if (pc !== 32'hFFFF_FFFC || instr_valid !== 1'b1 || instr !== 32'h0000_0033) begin
            errors++; $display("FAIL wrap_hold got pc=%h v=%b instr=%h exp pc=fffffffc v=1 instr=00000033", pc, instr_valid, instr);
        end
        tick();
        checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1 || misalign !== 1'b0) begin
            errors++; $display("FAIL wrap_addr got addr=%h req=%b mis=%b exp addr=00000000 req=1 mis=0", imem_addr, imem_req, misalign);
        end
    endtask

    task automatic test_reset_mid_fetch();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0073;
        tick();
        imem_ack = 1'b0;
        tick();
        checks++; if (pc !== 32'h0000_0004 || imem_req !== 1'b1) begin
            errors++; $display("FAIL rm_setup got pc=%h req=%b exp pc=00000004 req=1", pc, imem_req);
        end
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        #1 rst = 1'b1;
        #1;
        checks++; if (pc !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0 || instr !== NOP) begin
            errors++; $display("FAIL rm_async got pc=%h v=%b req=%b instr=%h exp pc=00000000 v=0 req=0 instr=%h", pc, instr_valid, imem_req, instr, NOP);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (instr_valid !== 1'b0 || instr !== NOP || pc !== 32'h0 || imem_req !== 1'b1) begin
            errors++; $display("FAIL rm_restart got v=%b instr=%h pc=%h req=%b exp v=0 instr=%h pc=00000000 req=1", instr_valid, instr, pc, imem_req, NOP);
        end
        imem_ack = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_zero_wait();
        test_delayed_ack();
        test_stall();
        test_redirect_hold();
        test_redirect_fetch();
        test_wrap();
        test_reset_mid_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
